// File: rtl/grant_decoder_if.sv
// ============================================================================
// Module      : grant_decoder_if
// Description : Index handshake and grant bus between the priority encoder
//               side and grant_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grant_decoder_if #(
    parameter int IDX_W = 2
);
    localparam int c_N = 2 ** IDX_W;

    logic             in_valid;
    logic [IDX_W-1:0] in_idx;
    logic             in_none;
    logic             in_ready;
    // "release" is a reserved word, hence release_req
    logic             release_req;
    logic [c_N-1:0]   grant;
    logic             grant_valid;
    logic             grant_done;
    logic [7:0]       grant_count;

    modport master (
        output in_valid, in_idx, in_none, release_req,
        input  in_ready, grant, grant_valid, grant_done, grant_count
    );

    modport slave (
        input  in_valid, in_idx, in_none, release_req,
        output in_ready, grant, grant_valid, grant_done, grant_count
    );
endinterface

`default_nettype wire

// File: rtl/grant_decoder.sv
// ============================================================================
// Module      : grant_decoder
// Description : Sequential 2-to-4 grant decoder with programmable hold time,
//               early release and a completed-grant counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grant_decoder #(
    parameter int          IDX_W       = 2,
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  wire            clk,
    input  wire            rst_n,
    grant_decoder_if.slave bus
);
    localparam int c_N = 2 ** IDX_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [c_N-1:0] grant_q, grant_d;
    logic [7:0]     count_q, count_d;

    logic w_last;
    logic w_ready;
    logic w_accept;

    // in_ready and grant_done depend only on state, cnt and release
    assign w_last   = (state_q == GRANT) && ((cnt_q == 8'd0) || bus.release_req);
    assign w_ready  = (state_q == IDLE) || w_last;
    assign w_accept = bus.in_valid && w_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        count_d = count_q;

        if (state_q == GRANT && !w_last) begin
            cnt_d = cnt_q - 8'd1;
        end

        if (w_last) begin
            state_d = IDLE;
            grant_d = '0;
            count_d = count_q + 8'd1;
        end

        // An accept in the last grant cycle loads the next grant with no gap
        if (w_accept) begin
            if (bus.in_none) begin
                state_d = IDLE;
                grant_d = '0;
            end else begin
                state_d = GRANT;
                grant_d = {{(c_N-1){1'b0}}, 1'b1} << bus.in_idx;
                cnt_d   = 8'(HOLD_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            grant_q <= '0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.grant       = grant_q;
    assign bus.grant_valid = (state_q == GRANT);
    assign bus.grant_done  = w_last;
    assign bus.grant_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_grant_decoder.sv
// ============================================================================
// Module      : tb_grant_decoder
// Description : Directed self-checking bench for grant_decoder (hold 3 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grant_decoder;
    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    grant_decoder_if #(.IDX_W(2)) bus_a ();
    grant_decoder_if #(.IDX_W(2)) bus_b ();

    grant_decoder #(.IDX_W(2), .HOLD_CYCLES(3)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a.slave)
    );

    grant_decoder #(.IDX_W(2), .HOLD_CYCLES(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] onehot(input int k);
        return 32'd1 << k;
    endfunction

    initial begin
        int seq[3];
        seq = '{3, 0, 1};

        bus_a.in_valid = 1'b0; bus_a.in_idx = 2'd0; bus_a.in_none = 1'b0; bus_a.release_req = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_idx = 2'd0; bus_b.in_none = 1'b0; bus_b.release_req = 1'b0;

        // Reset
        tick(); tick();
        check("rst_grant", 32'(bus_a.grant), 32'h0);
        check("rst_valid", 32'(bus_a.grant_valid), 32'h0);
        check("rst_done", 32'(bus_a.grant_done), 32'h0);
        check("rst_ready", 32'(bus_a.in_ready), 32'h1);
        check("rst_count", 32'(bus_a.grant_count), 32'h0);

        // Basic grant on index 2
        rst_n_a = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.in_idx = 2'd2;
        tick();
        bus_a.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("basic_grant", 32'(bus_a.grant), 32'h4);
            check("basic_valid", 32'(bus_a.grant_valid), 32'h1);
            check("basic_done", 32'(bus_a.grant_done), (c == 2) ? 32'h1 : 32'h0);
            check("basic_ready", 32'(bus_a.in_ready), (c == 2) ? 32'h1 : 32'h0);
            tick();
        end
        check("basic_after_grant", 32'(bus_a.grant), 32'h0);
        check("basic_after_valid", 32'(bus_a.grant_valid), 32'h0);
        check("basic_count", 32'(bus_a.grant_count), 32'd1);

        // Back-to-back 3, 0, 1
        bus_a.in_valid = 1'b1; bus_a.in_idx = 2'(seq[0]);
        tick();
        for (int g = 0; g < 3; g++) begin
            if (g < 2) bus_a.in_idx = 2'(seq[g+1]);
            else       bus_a.in_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                check("b2b_grant", 32'(bus_a.grant), onehot(seq[g]));
                check("b2b_valid", 32'(bus_a.grant_valid), 32'h1);
                check("b2b_ready", 32'(bus_a.in_ready), (c == 2) ? 32'h1 : 32'h0);
                check("b2b_done", 32'(bus_a.grant_done), (c == 2) ? 32'h1 : 32'h0);
                tick();
            end
        end
        check("b2b_after_grant", 32'(bus_a.grant), 32'h0);
        check("b2b_count", 32'(bus_a.grant_count), 32'd4);

        // Early release in the first grant cycle
        bus_a.in_valid = 1'b1; bus_a.in_idx = 2'd1;
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.release_req = 1'b1;
        #1;
        check("rel1_grant", 32'(bus_a.grant), 32'h2);
        check("rel1_done", 32'(bus_a.grant_done), 32'h1);
        check("rel1_ready", 32'(bus_a.in_ready), 32'h1);
        tick();
        bus_a.release_req = 1'b0;
        #1;
        check("rel1_after_grant", 32'(bus_a.grant), 32'h0);
        check("rel1_after_done", 32'(bus_a.grant_done), 32'h0);
        check("rel1_count", 32'(bus_a.grant_count), 32'd5);
        tick();
        check("rel1_count_hold", 32'(bus_a.grant_count), 32'd5);

        // Release in the natural last cycle
        bus_a.in_valid = 1'b1; bus_a.in_idx = 2'd1;
        tick();
        bus_a.in_valid = 1'b0;
        check("rel3_c1_done", 32'(bus_a.grant_done), 32'h0);
        tick();
        check("rel3_c2_done", 32'(bus_a.grant_done), 32'h0);
        tick();
        bus_a.release_req = 1'b1;
        #1;
        check("rel3_c3_done", 32'(bus_a.grant_done), 32'h1);
        check("rel3_c3_grant", 32'(bus_a.grant), 32'h2);
        tick();
        bus_a.release_req = 1'b0;
        #1;
        check("rel3_after_grant", 32'(bus_a.grant), 32'h0);
        check("rel3_after_done", 32'(bus_a.grant_done), 32'h0);
        check("rel3_count", 32'(bus_a.grant_count), 32'd6);

        // in_none consumes the index without granting
        bus_a.in_valid = 1'b1; bus_a.in_none = 1'b1; bus_a.in_idx = 2'd3;
        #1;
        check("none_ready", 32'(bus_a.in_ready), 32'h1);
        tick();
        bus_a.in_valid = 1'b0; bus_a.in_none = 1'b0;
        check("none_grant", 32'(bus_a.grant), 32'h0);
        check("none_valid", 32'(bus_a.grant_valid), 32'h0);
        check("none_count", 32'(bus_a.grant_count), 32'd6);
        tick();
        check("none_count_hold", 32'(bus_a.grant_count), 32'd6);

        // Reset in the 2nd cycle of a grant, with a new request pending
        bus_a.in_valid = 1'b1; bus_a.in_idx = 2'd0;
        tick();
        bus_a.in_valid = 1'b0;
        check("midrst_c1_grant", 32'(bus_a.grant), 32'h1);
        tick();
        rst_n_a = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_idx = 2'd2;
        tick();
        rst_n_a = 1'b1;
        bus_a.in_valid = 1'b0;
        check("midrst_grant", 32'(bus_a.grant), 32'h0);
        check("midrst_ready", 32'(bus_a.in_ready), 32'h1);
        check("midrst_count", 32'(bus_a.grant_count), 32'h0);
        check("midrst_valid", 32'(bus_a.grant_valid), 32'h0);
        tick();
        check("midrst_not_granted", 32'(bus_a.grant), 32'h0);

        // Wrap with HOLD_CYCLES=1: 256 single-cycle back-to-back grants
        rst_n_b = 1'b1;
        bus_b.in_valid = 1'b1; bus_b.in_idx = 2'd0;
        for (int i = 0; i < 256; i++) begin
            tick();
            bus_b.in_idx = 2'((i + 1) % 4);
            if (i == 255) bus_b.in_valid = 1'b0;
            check("wrap_grant", 32'(bus_b.grant), onehot(i % 4));
            check("wrap_done", 32'(bus_b.grant_done), 32'h1);
            check("wrap_count", 32'(bus_b.grant_count), 32'(i));
        end
        tick();
        check("wrap_final_count", 32'(bus_b.grant_count), 32'h0);
        check("wrap_final_grant", 32'(bus_b.grant), 32'h0);
        check("wrap_final_valid", 32'(bus_b.grant_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
